// File: rtl/data_mem_responder_if.sv
// ----------------------------------------------------------------------------
// data_mem_responder_if
//   CPU-side data memory bus for data_mem_responder.
//   Ports / signals:
//     MemWrite    store request for the current cycle
//     Mem_WrAddr  byte address for both load and store
//     Mem_WrData  store data; the bytes to store sit in the low bits
//     Funct3      access size: 000 B, 001 H, 010 W, 100 BU, 101 HU
//     ReadData    load data, extended to 32 bits (combinational)
//   Modports: master = CPU side, slave = memory/peripheral side.
// ----------------------------------------------------------------------------
interface data_mem_responder_if;
    logic        MemWrite;
    logic [31:0] Mem_WrAddr;
    logic [31:0] Mem_WrData;
    logic [2:0]  Funct3;
    logic [31:0] ReadData;

    modport master (
        output MemWrite,
        output Mem_WrAddr,
        output Mem_WrData,
        output Funct3,
        input  ReadData
    );

    modport slave (
        input  MemWrite,
        input  Mem_WrAddr,
        input  Mem_WrData,
        input  Funct3,
        output ReadData
    );
endinterface

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
//   Zero-wait-state data memory for a single-cycle CPU: a DEPTH-word byte-lane
//   RAM plus a 16-byte MMIO window (cycle counter, GPIO, timer compare, status).
//   Loads are purely combinational; stores and register updates happen on the
//   rising clock edge.
//   Ports:
//     clk          single clock, rising edge
//     reset        asynchronous, active-low reset (RAM contents are kept)
//     bus          data_mem_responder_if.slave (MemWrite, Mem_WrAddr,
//                  Mem_WrData, Funct3 in; ReadData out)
//     gpio_out     registered GPIO output (GPIO[7:0])
//     timer_irq    timer interrupt flag, set on CNT == CMP (CMP != 0)
//     misalign_err sticky flag for a misaligned / invalid-size RAM access
//   MMIO map (word access only): +0 CNT (RO), +4 GPIO, +8 CMP, +C STAT (W1C).
// ----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] MMIO_BASE = 32'h0000_1000
) (
    input  logic                  clk,
    input  logic                  reset,
    data_mem_responder_if.slave   bus,
    output logic [7:0]            gpio_out,
    output logic                  timer_irq,
    output logic                  misalign_err
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

    typedef enum logic [1:0] {
        REG_CNT  = 2'd0,
        REG_GPIO = 2'd1,
        REG_CMP  = 2'd2,
        REG_STAT = 2'd3
    } mmioReg_e;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [31:0]   ram [DEPTH];
    logic [31:0]   cnt;
    logic [31:0]   cmp;
    logic [7:0]    gpio;

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    logic [31:0]   addr;
    logic [2:0]    f3;
    logic [AW-1:0] wordIdx;
    logic          accByte;
    logic          accHalf;
    logic          accWord;
    logic          f3Valid;
    logic          misaligned;
    logic          inRam;
    logic          ramOk;
    logic [31:0]   mmioOff;
    logic          inMmio;
    logic          mmioWord;
    mmioReg_e      regSel;
    logic [3:0]    byteEn;
    logic [31:0]   wrLanes;

    assign addr    = bus.Mem_WrAddr;
    assign f3      = bus.Funct3;
    assign wordIdx = addr[AW+1:2];

    always_comb begin
        accByte = 1'b0;
        accHalf = 1'b0;
        accWord = 1'b0;
        f3Valid = 1'b1;
        case (f3)
            3'b000, 3'b100: accByte = 1'b1;
            3'b001, 3'b101: accHalf = 1'b1;
            3'b010:         accWord = 1'b1;
            default:        f3Valid = 1'b0;
        endcase
    end

    // Invalid size codes fold into the misaligned path so they never touch RAM.
    assign misaligned = !f3Valid
                      | (accHalf & addr[0])
                      | (accWord & (addr[1:0] != 2'b00));

    assign inRam    = addr < RAM_BYTES;
    assign ramOk    = inRam && !misaligned;

    // RAM decode takes precedence should the window ever overlap the RAM.
    assign mmioOff  = addr - MMIO_BASE;
    assign inMmio   = !inRam && (mmioOff < 32'd16);
    assign mmioWord = inMmio && accWord && (mmioOff[1:0] == 2'b00);
    assign regSel   = mmioReg_e'(mmioOff[3:2]);

    always_comb begin
        byteEn  = 4'b0000;
        wrLanes = bus.Mem_WrData;
        if (accByte) begin
            byteEn  = 4'b0001 << addr[1:0];
            wrLanes = {4{bus.Mem_WrData[7:0]}};
        end else if (accHalf) begin
            byteEn  = addr[1] ? 4'b1100 : 4'b0011;
            wrLanes = {2{bus.Mem_WrData[15:0]}};
        end else if (accWord) begin
            byteEn  = 4'b1111;
        end
    end

    // ------------------------------------------------------------------
    // RAM store (no reset: contents survive reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (bus.MemWrite && ramOk) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (byteEn[i]) begin
                    ram[wordIdx][8*i +: 8] <= wrLanes[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Combinational load path
    // ------------------------------------------------------------------
    logic [31:0] ramWord;
    logic [7:0]  laneByte;
    logic [15:0] laneHalf;

    assign ramWord = ram[wordIdx];

    always_comb begin
        case (addr[1:0])
            2'd0:    laneByte = ramWord[7:0];
            2'd1:    laneByte = ramWord[15:8];
            2'd2:    laneByte = ramWord[23:16];
            default: laneByte = ramWord[31:24];
        endcase
        laneHalf = addr[1] ? ramWord[31:16] : ramWord[15:0];
    end

    always_comb begin
        bus.ReadData = '0;
        if (ramOk) begin
            case (f3)
                3'b000:  bus.ReadData = {{24{laneByte[7]}}, laneByte};
                3'b100:  bus.ReadData = {24'd0, laneByte};
                3'b001:  bus.ReadData = {{16{laneHalf[15]}}, laneHalf};
                3'b101:  bus.ReadData = {16'd0, laneHalf};
                3'b010:  bus.ReadData = ramWord;
                default: bus.ReadData = '0;
            endcase
        end else if (mmioWord) begin
            case (regSel)
                REG_CNT:  bus.ReadData = cnt;
                REG_GPIO: bus.ReadData = {24'd0, gpio};
                REG_CMP:  bus.ReadData = cmp;
                REG_STAT: bus.ReadData = {30'd0, misalign_err, timer_irq};
                default:  bus.ReadData = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // MMIO registers and flags
    // ------------------------------------------------------------------
    logic        mmioWr;
    logic [1:0]  statClr;
    logic        irqSet;
    logic        errSet;

    assign mmioWr  = bus.MemWrite && mmioWord;
    assign statClr = (mmioWr && regSel == REG_STAT) ? bus.Mem_WrData[1:0] : 2'b00;
    // Compare against the registered CMP so a CMP write only matters next cycle.
    assign irqSet  = (cnt == cmp) && (cmp != '0);
    // Every presented access is a load, so a bad RAM access flags even without MemWrite.
    assign errSet  = inRam && misaligned;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt          <= '0;
            gpio         <= '0;
            cmp          <= '0;
            timer_irq    <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            cnt <= cnt + 32'd1;
            if (mmioWr && regSel == REG_GPIO) begin
                gpio <= bus.Mem_WrData[7:0];
            end
            if (mmioWr && regSel == REG_CMP) begin
                cmp <= bus.Mem_WrData;
            end
            // A set event on the same edge as a W1C clear wins.
            timer_irq    <= irqSet | (timer_irq & ~statClr[0]);
            misalign_err <= errSet | (misalign_err & ~statClr[1]);
        end
    end

    assign gpio_out = gpio;

endmodule
